// File: rtl/pim_wbuf_pkg.sv
// Shared types and sizing helpers for the PIM weight loader.
// FSM state, default widths and beat counter sizing.
package pim_wbuf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ROW_W_DEF  = 256;

  function automatic int beats_of(int data_w, int row_w);
    return row_w / (data_w / 2);
  endfunction

  function automatic int cnt_w(int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/pim_weight_loader_if.sv
// Weight bus handshake between the host and the loader.
// The master drives words; the slave signals acceptance.
interface pim_weight_loader_if #(
  parameter int DATA_W = 32
);
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;

  modport master (
    output wvalid,
    output wdata,
    input  wready
  );

  modport slave (
    input  wvalid,
    input  wdata,
    output wready
  );
endinterface

// File: rtl/pim_wbuf_bank.sv
// One weight plane: shadow row filled slice by slice,
// plus an active row that only changes on commit.
module pim_wbuf_bank #(
  parameter int H     = 16,
  parameter int ROW_W = 256,
  parameter int KW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [KW-1:0]    k,
  input  logic [H-1:0]     wr_data,
  input  logic             commit,
  output logic [ROW_W-1:0] active
);

  logic [ROW_W-1:0] shadow;

  // Beat 0 lands in the MSB slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wr_en)
        shadow[ROW_W-1-int'(k)*H -: H] <= wr_data;
      if (commit)
        active <= shadow;
    end
  end

endmodule

// File: rtl/pim_weight_loader.sv
// Double-buffered weight loader: FSM, beat counter, handshake
// and error logic driving a CAM bank and a CIM bank.
module pim_weight_loader
  import pim_wbuf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROW_W  = ROW_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_start,
  pim_weight_loader_if.slave bus,
  output logic             o_load_done,
  output logic             o_shadow_full,
  input  logic             i_commit,
  output logic             o_active_valid,
  input  logic             i_out_en,
  output logic [ROW_W-1:0] o_cam_data,
  output logic [ROW_W-1:0] o_cim_data,
  output logic             o_err
);

  localparam int H     = DATA_W / 2;
  localparam int BEATS = beats_of(DATA_W, ROW_W);
  localparam int KW    = cnt_w(BEATS);
  localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic             wready;
  logic             wr_en;
  logic             commit;
  logic [ROW_W-1:0] cam_active;
  logic [ROW_W-1:0] cim_active;

  assign bus.wready = wready;
  assign wr_en  = (state == LOAD) && bus.wvalid && !i_load_start;
  assign commit = (state == FULL) && i_commit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      k              <= '0;
      wready         <= 1'b0;
      o_shadow_full  <= 1'b0;
      o_load_done    <= 1'b0;
      o_active_valid <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      o_load_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_load_start) begin
            state  <= LOAD;
            k      <= '0;
            wready <= 1'b1;
            o_err  <= 1'b0;
          end
          if (i_commit)
            o_err <= 1'b1;
        end
        LOAD: begin
          if (i_load_start) begin
            k     <= '0;
            o_err <= 1'b0;
          end else if (wr_en) begin
            if (k == K_LAST) begin
              state         <= FULL;
              wready        <= 1'b0;
              o_shadow_full <= 1'b1;
              o_load_done   <= 1'b1;
            end else begin
              k <= k + 1'b1;
            end
          end
          if (i_commit)
            o_err <= 1'b1;
        end
        FULL: begin
          if (i_commit)
            o_active_valid <= 1'b1;
          // Restart wins the next state; a same-cycle commit still lands.
          if (i_load_start) begin
            state         <= LOAD;
            k             <= '0;
            wready        <= 1'b1;
            o_shadow_full <= 1'b0;
            o_err         <= 1'b0;
          end else if (i_commit) begin
            state         <= IDLE;
            o_shadow_full <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pim_wbuf_bank #(.H(H), .ROW_W(ROW_W), .KW(KW)) u_cam (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (wr_en),
    .k       (k),
    .wr_data (bus.wdata[DATA_W-1:H]),
    .commit  (commit),
    .active  (cam_active)
  );

  pim_wbuf_bank #(.H(H), .ROW_W(ROW_W), .KW(KW)) u_cim (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (wr_en),
    .k       (k),
    .wr_data (bus.wdata[H-1:0]),
    .commit  (commit),
    .active  (cim_active)
  );

  assign o_cam_data = (i_out_en && o_active_valid) ? cam_active : '0;
  assign o_cim_data = (i_out_en && o_active_valid) ? cim_active : '0;

endmodule

// File: tb/tb_pim_weight_loader.sv
// Directed bench for pim_weight_loader at default and
// narrow parameters.
module tb_pim_weight_loader;

  logic clk;
  logic rst_n;

  logic         ls0, cm0, oe0;
  logic         ld0, sf0, av0, er0;
  logic [255:0] cam0, cim0;

  logic         ls1, cm1, oe1;
  logic         ld1, sf1, av1, er1;
  logic [63:0]  cam1, cim1;

  int errors = 0;
  int checks = 0;

  pim_weight_loader_if #(.DATA_W(32)) bus0 ();
  pim_weight_loader_if #(.DATA_W(16)) bus1 ();

  pim_weight_loader #(.DATA_W(32), .ROW_W(256)) u0 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_start   (ls0),
    .bus            (bus0),
    .o_load_done    (ld0),
    .o_shadow_full  (sf0),
    .i_commit       (cm0),
    .o_active_valid (av0),
    .i_out_en       (oe0),
    .o_cam_data     (cam0),
    .o_cim_data     (cim0),
    .o_err          (er0)
  );

  pim_weight_loader #(.DATA_W(16), .ROW_W(64)) u1 (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_start   (ls1),
    .bus            (bus1),
    .o_load_done    (ld1),
    .o_shadow_full  (sf1),
    .i_commit       (cm1),
    .o_active_valid (av1),
    .i_out_en       (oe1),
    .o_cam_data     (cam1),
    .o_cim_data     (cim1),
    .o_err          (er1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat0(input logic [31:0] d);
    bus0.wvalid = 1'b1;
    bus0.wdata  = d;
    tick();
    bus0.wvalid = 1'b0;
  endtask

  task automatic pulse_start0();
    ls0 = 1'b1;
    tick();
    ls0 = 1'b0;
  endtask

  task automatic pulse_commit0();
    cm0 = 1'b1;
    tick();
    cm0 = 1'b0;
  endtask

  logic [255:0] exp_a, exp_bc, exp_bi, exp_dc, exp_di, exp_ec;
  logic [63:0]  exp1c, exp1i;
  int ld_cnt, k, cyc;
  logic v;

  initial begin
    rst_n = 1'b0;
    ls0 = 0; cm0 = 0; oe0 = 1;
    ls1 = 0; cm1 = 0; oe1 = 1;
    bus0.wvalid = 0; bus0.wdata = '0;
    bus1.wvalid = 0; bus1.wdata = '0;

    exp_a = '0; exp_bc = '0; exp_bi = '0;
    exp_dc = '0; exp_di = '0; exp_ec = '0;
    for (int i = 0; i < 16; i++) begin
      exp_a[255-16*i -: 16]  = 16'(i);
      exp_bc[255-16*i -: 16] = 16'(16'h0100 + i);
      exp_bi[255-16*i -: 16] = 16'(16'h0200 + i);
      exp_dc[255-16*i -: 16] = (i == 0) ? 16'h1234 : 16'hAAAA;
      exp_di[255-16*i -: 16] = (i == 0) ? 16'h5678 : 16'h5555;
    end
    exp_ec[255:240] = 16'hFFFF;
    exp1c = 64'hC0C1_C2C3_C4C5_C6C7;
    exp1i = 64'h3031_3233_3435_3637;

    // Reset defaults
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_cam", cam0, '0);
    chk("rst_cim", cim0, '0);
    chk("rst_wready", bus0.wready, 0);
    chk("rst_full", sf0, 0);
    chk("rst_valid", av0, 0);
    chk("rst_err", er0, 0);
    chk("rst_done", ld0, 0);

    // Full load and commit
    pulse_start0();
    chk("load_wready", bus0.wready, 1);
    ld_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      beat0({16'(i), 16'(i)});
      if (ld0) ld_cnt++;
    end
    chk("done_once", 32'(ld_cnt), 1);
    chk("done_now", ld0, 1);
    chk("full_flag", sf0, 1);
    chk("full_wready", bus0.wready, 0);
    beat0(32'hDEAD_BEEF);
    chk("done_drop", ld0, 0);
    chk("pre_commit_cam", cam0, '0);
    pulse_commit0();
    chk("a_cam", cam0, exp_a);
    chk("a_cim", cim0, exp_a);
    chk("a_msb", 256'(cam0[255:240]), 256'(16'h0000));
    chk("a_lsb", 256'(cam0[15:0]), 256'(16'h000F));
    chk("a_mid", 256'(cam0[159:144]), 256'(16'h0006));
    chk("a_valid", av0, 1);
    chk("idle_wready", bus0.wready, 0);

    // Stalled load of row B while row A drives
    pulse_start0();
    k = 0; cyc = 0;
    while (k < 16 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      bus0.wvalid = v;
      bus0.wdata  = {16'(16'h0100 + k), 16'(16'h0200 + k)};
      tick();
      if (v) k++;
      cyc++;
      if (k == 8 && v) begin
        chk("stream_cam", cam0, exp_a);
        chk("stream_wready", bus0.wready, 1);
      end
    end
    bus0.wvalid = 0;
    chk("stall_bound", 32'(k), 16);
    chk("stall_full", sf0, 1);
    chk("stall_hold", cim0, exp_a);
    pulse_commit0();
    chk("b_cam", cam0, exp_bc);
    chk("b_cim", cim0, exp_bi);
    oe0 = 0;
    #1;
    chk("gate_cam", cam0, '0);
    chk("gate_cim", cim0, '0);
    oe0 = 1;

    // Commit during load, then restart at k=5
    pulse_start0();
    for (int i = 0; i < 3; i++) beat0(32'h0BAD_0BAD);
    pulse_commit0();
    chk("err_set", er0, 1);
    chk("err_active", cam0, exp_bc);
    beat0(32'h0BAD_0BAD);
    beat0(32'h0BAD_0BAD);
    pulse_start0();
    chk("err_clr", er0, 0);
    beat0(32'h1234_5678);
    for (int i = 1; i < 16; i++) beat0(32'hAAAA_5555);
    chk("d_full", sf0, 1);

    // Commit and restart in the same FULL cycle
    cm0 = 1; ls0 = 1;
    tick();
    cm0 = 0; ls0 = 0;
    chk("d_cam", cam0, exp_dc);
    chk("d_cim", cim0, exp_di);
    chk("cs_wready", bus0.wready, 1);
    chk("cs_full", sf0, 0);
    beat0(32'hFFFF_0000);
    for (int i = 1; i < 16; i++) beat0(32'h0);
    pulse_commit0();
    chk("e_cam", cam0, exp_ec);

    // Narrow instance: 8 beats of 8-bit halves
    ls1 = 1; tick(); ls1 = 0;
    for (int i = 0; i < 8; i++) begin
      bus1.wvalid = 1;
      bus1.wdata  = {8'(8'hC0 + i), 8'(8'h30 + i)};
      tick();
    end
    bus1.wvalid = 0;
    chk("n_full", sf1, 1);
    cm1 = 1; tick(); cm1 = 0;
    chk("n_cam", 256'(cam1), 256'(exp1c));
    chk("n_cim", 256'(cim1), 256'(exp1i));
    chk("n_lsb", 256'(cam1[7:0]), 256'(8'hC7));

    // Asynchronous reset mid-load
    pulse_start0();
    for (int i = 0; i < 3; i++) beat0(32'h1111_2222);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cam", cam0, '0);
    chk("ar_cim", cim0, '0);
    chk("ar_wready", bus0.wready, 0);
    chk("ar_valid", av0, 0);
    chk("ar_n_cam", 256'(cam1), '0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
